// File: rtl/nibble_serial_tx_if.sv
// Parallel-word handshake between the upstream D-register stage and nibble_serial_tx.
interface nibble_serial_tx_if #(
    parameter int unsigned DATA_W = 4
);
    logic [DATA_W-1:0] d_in;
    logic              d_valid;
    logic              d_ready;

    modport master (output d_in, output d_valid, input d_ready);
    modport slave  (input d_in, input d_valid, output d_ready);
endinterface

// File: rtl/nibble_serial_tx.sv
// Serializer: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Parity slot is built only when NIBBLE_SERIAL_TX_PARITY_EN is defined.
module nibble_serial_tx #(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    nibble_serial_tx_if.slave bus,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int unsigned BW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state_q;
    logic [BW-1:0]     baud_q;
    logic [BCW-1:0]    bit_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
    logic              parity_q;
`endif

    assign shift_d     = shift_q >> 1;
    assign bus.d_ready = (state_q == S_IDLE) && !rst;
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Outputs are registered one state ahead, so each transition loads the value for the next slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.d_valid) begin
                        shift_q  <= bus.d_in;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
                        parity_q <= ^bus.d_in;
`endif
                        state_q  <= S_START;
                        baud_q   <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == BIT_LAST) begin
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                            done_q  <= (CLKS_PER_BIT == 1);
`endif
                        end else begin
                            bit_q   <= bit_q + BCW'(1);
                            shift_q <= shift_d;
                            tx_q    <= shift_d[0];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        done_q  <= (CLKS_PER_BIT == 1);
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    // done is raised one cycle early so the registered pulse lands on the final stop cycle.
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                        done_q <= (baud_q == BAUD_PRE);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_tx.sv
// Scoreboard bench for nibble_serial_tx: accepted words are queued, a monitor checks each frame cycle by cycle.
module tb_nibble_serial_tx;
    localparam int DW  = 4;
    localparam int CPB = 4;
`ifdef NIBBLE_SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LEN = (DW + 2 + PAR) * CPB;

    logic clk;
    logic rst;
    logic tx;
    logic busy;
    logic done;

    nibble_serial_tx_if #(.DATA_W(DW)) bus ();

    nibble_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic          active = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: line level at cycle k of a frame, derived from the slot the cycle falls in.
    function automatic logic exp_tx(input logic [DW-1:0] w, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DW) return w[slot-1];
        if (PAR == 1 && slot == DW + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, pops a word whenever a frame begins.
    initial begin
        logic [DW-1:0] cur;
        int   k;
        logic gap;
        logic prev_rst;
        cur = '0;
        k = 0;
        gap = 1'b0;
        prev_rst = 1'b1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                chk("reset_tx", tx, 1'b1);
                chk("reset_busy", busy, 1'b0);
                chk("reset_done", done, 1'b0);
                chk("reset_ready", bus.d_ready, !rst);
                active = 1'b0;
                gap = 1'b0;
            end else begin
                if (!active && busy) begin
                    if (gap) chk("idle_gap", busy, 1'b0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1'b1, 1'b0);
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    active = 1'b1;
                    k = 0;
                end
                gap = 1'b0;
                if (active) begin
                    chk("tx_bit", tx, exp_tx(cur, k));
                    chk("done", done, (k == LEN - 1));
                    chk("busy", busy, 1'b1);
                    chk("ready_busy", bus.d_ready, 1'b0);
                    k++;
                    if (k == LEN) begin
                        active = 1'b0;
                        gap = 1'b1;
                    end
                end else begin
                    chk("idle_tx", tx, 1'b1);
                    chk("idle_done", done, 1'b0);
                    chk("idle_ready", bus.d_ready, !rst);
                end
            end
            prev_rst = rst;
        end
    end

    task automatic send(input logic [DW-1:0] w);
        logic acc;
        acc = 1'b0;
        bus.d_in = w;
        bus.d_valid = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if (bus.d_ready && !rst) begin
                exp_q.push_back(w);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 1'b1, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic drained;
        rst = 1'b1;
        bus.d_valid = 1'b1;
        bus.d_in = 4'h6;
        idle_cycles(2);
        rst = 1'b0;
        bus.d_valid = 1'b0;
        idle_cycles(3);

        send(4'b1010);
        bus.d_valid = 1'b0;
        idle_cycles(30);

        send(4'hF);
        send(4'h3);
        bus.d_valid = 1'b0;
        idle_cycles(30);

        send(4'h5);
        bus.d_in = 4'hA;
        bus.d_valid = 1'b0;
        idle_cycles(30);

        send(4'h9);
        bus.d_valid = 1'b0;
        idle_cycles(9);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(2);
        send(4'h6);
        bus.d_valid = 1'b0;
        idle_cycles(30);

        send(4'b0111);
        bus.d_valid = 1'b0;
        idle_cycles(5);

        for (int i = 0; i < 40; i++) begin
            send(DW'($urandom));
            bus.d_in = DW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                bus.d_valid = 1'b0;
                idle_cycles($urandom_range(0, 30));
            end
        end
        bus.d_valid = 1'b0;

        drained = 1'b0;
        for (int c = 0; c < 500 && !drained; c++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !active && !busy) drained = 1'b1;
        end
        if (!drained) chk("drain_timeout", 1'b1, 1'b0);
        idle_cycles(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_tx.md
Name: nibble_serial_tx

Overview:
- Transmit side of the team's 4-bit register data path: takes a parallel word through a valid/ready handshake and shifts it out on a single serial line.
- Frame format: start bit, DATA_W data bits LSB first, optional parity bit, stop bit.
- Sits between a parallel D-register stage and a serial link whose far end is a matching deserializer.

Parameters:
DATA_W, 4, data word width in bits (>=1)
CLKS_PER_BIT, 4, clk cycles each serial bit is held on tx (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
d_in  input  DATA_W  parallel word to send
d_valid  input  1  d_in is valid
d_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- One clock, clk. Reset is synchronous, active-high on rst. All state is updated only on the rising edge of clk.
- Reset values: state=IDLE, tx=1, busy=0, done=0, bit counter=0, baud counter=0. d_ready=1 from the first edge after rst deasserts.
- While rst=1, d_valid is ignored and no word is accepted.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- d_ready = (state==IDLE) && !rst. This output is combinational.
- Acceptance: d_valid && d_ready at a clk edge.
  - d_in is latched into the shift register; the state goes to START.
  - tx=0 and busy=1 from the next cycle.
- After acceptance, d_in and d_valid are don't-care until d_ready returns.
- Each bit is held for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1; the state advances on wrap.
- DATA state:
  - tx = shift_reg[0]; the register shifts right on each bit boundary.
  - Bit counter runs 0..DATA_W-1; leave DATA on the last bit's wrap.
- STOP state:
  - tx=1.
  - done=1 only on the final cycle of STOP.
  - The next state is IDLE; busy=0 and d_ready=1 in that IDLE cycle.
- Frame length from the first tx=0 cycle to the end of stop: (DATA_W+2)*CLKS_PER_BIT cycles, or (DATA_W+3)*CLKS_PER_BIT with parity.
- Back-to-back words:
  - A new word can be accepted in the first IDLE cycle after done.
  - This guarantees at least one idle tx=1 cycle between frames, no overlap.
- CLKS_PER_BIT=1 gives one cycle per bit; there are no special cases.
- Reset mid-frame:
  - The frame is aborted; tx=1 and busy=0 from the next edge. No done pulse.
  - The partially sent word is discarded.
- The IDLE line stays high indefinitely when d_valid=0.

Optional Feature:
NIBBLE_SERIAL_TX_PARITY_EN
- Defined:
  - The PARITY state is inserted between DATA and STOP.
  - tx carries the even-parity bit (XOR of the latched word) for CLKS_PER_BIT cycles.
  - Frame = (DATA_W+3)*CLKS_PER_BIT cycles.
- Undefined: the PARITY state and its logic are absent; DATA goes directly to STOP.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> tx=1, busy=0, done=0 throughout; d_ready=1 after release.
- Single word (DATA_W=4, CLKS_PER_BIT=4), d_in=4'b1010 accepted at cycle T -> tx pattern per 4-cycle slot from T+1 is 0,0,1,0,1,1; done=1 at cycle T+24 only; d_ready=1 at T+25.
- Back-to-back: d_valid held high with 4'hF then 4'h3 -> second accepted at the first cycle after done; tx=1 for exactly that one cycle between frames; second frame is 0,1,1,0,0,1.
- Input stability: d_in changed from 4'h5 to 4'hA one cycle after acceptance -> serial data is still 1,0,1,0 (for 4'h5); d_ready=0 during the frame.
- Reset mid-frame: rst=1 during the 2nd data bit -> tx=1 and busy=0 from the next edge; no done pulse; d_ready=1 after release; the next word transmits normally.
- Parity (macro defined): d_in=4'b0111 -> data 1,1,1,0, then parity slot tx=1, then stop; frame is 28 cycles; done at T+28.
